// File: rtl/regfile_sb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared constants and types for the scoreboarded register file.
//   XLEN_DEF  : default register data width
//   NREGS_DEF : default register count (power of two)
//   NRD_DEF   : default number of read ports
//   IDXW_DEF  : register-index width for the default register count
//   reg_idx_t : register-index type for the default configuration
// ----------------------------------------------------------------------------
package regfile_sb_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 2;
   localparam int IDXW_DEF  = $clog2(NREGS_DEF);

   typedef logic [IDXW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_sb_if
// Bus bundle between the issue/writeback logic and the register file.
//   i_rf_rs_idx    : read index per port (port k at bits k*IDXW)
//   o_rf_rs        : read data per port (port k at bits k*XLEN)
//   o_rf_rs_busy   : per-port busy flag of the addressed source register
//   i_rf_wen       : writeback valid
//   i_rf_rdidx     : writeback destination index
//   i_rf_wdat      : writeback data
//   i_sb_alloc     : request to mark a destination pending
//   i_sb_alloc_idx : destination being allocated
//   o_sb_alloc_rdy : allocation accepted this cycle
//   o_sb_pend_cnt  : number of busy registers
// Modports: master (pipeline side), slave (register file side).
// ----------------------------------------------------------------------------
interface regfile_sb_if
   import regfile_sb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = NRD_DEF
);
   localparam int IDXW = $clog2(NREGS);

   logic [NRD*IDXW-1:0] i_rf_rs_idx;
   logic [NRD*XLEN-1:0] o_rf_rs;
   logic [NRD-1:0]      o_rf_rs_busy;
   logic                i_rf_wen;
   logic [IDXW-1:0]     i_rf_rdidx;
   logic [XLEN-1:0]     i_rf_wdat;
   logic                i_sb_alloc;
   logic [IDXW-1:0]     i_sb_alloc_idx;
   logic                o_sb_alloc_rdy;
   logic [IDXW:0]       o_sb_pend_cnt;

   modport master (
      output i_rf_rs_idx, i_rf_wen, i_rf_rdidx, i_rf_wdat, i_sb_alloc, i_sb_alloc_idx,
      input  o_rf_rs, o_rf_rs_busy, o_sb_alloc_rdy, o_sb_pend_cnt
   );

   modport slave (
      input  i_rf_rs_idx, i_rf_wen, i_rf_rdidx, i_rf_wdat, i_sb_alloc, i_sb_alloc_idx,
      output o_rf_rs, o_rf_rs_busy, o_sb_alloc_rdy, o_sb_pend_cnt
   );
endinterface

// File: rtl/regfile_dfflr.sv
// ----------------------------------------------------------------------------
// regfile_dfflr
// One register of the file: W-bit flop with load enable and synchronous
// active-high clear (clear has priority over load).
//   clk : clock
//   clr : synchronous clear
//   ld  : load enable
//   d   : load data
//   q   : stored value
// ----------------------------------------------------------------------------
module regfile_dfflr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (clr)     q <= '0;
      else if (ld) q <= d;
   end
endmodule

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
// Register file with a one-bit-per-register scoreboard. Register 0 is
// hard-wired to zero and never becomes busy. Reads are combinational.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset (clears data, busy bits, counter)
//   bus : regfile_sb_if.slave (read ports, writeback, allocation, count)
// Optional feature macro: REGFILE_SB_BYPASS_EN -- when defined, a read of the
// register being written this cycle returns the write data and not-busy.
// ----------------------------------------------------------------------------
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = NRD_DEF
) (
   input  logic         clk,
   input  logic         rst,
   regfile_sb_if.slave  bus
);
   localparam int IDXW = $clog2(NREGS);

   logic [XLEN-1:0]          rf_q [NREGS];
   logic [NREGS-1:0]         busy_q;
   logic [NREGS-1:0]         busy_nxt;
   logic [IDXW:0]            pend_q;
   logic [NRD-1:0][XLEN-1:0] rs_data;
   logic [NRD-1:0]           rs_busy;

   logic wr_fire;
   logic alloc_rdy;
   logic alloc_fire;
   logic cnt_inc;
   logic cnt_dec;

   // A writeback to the same index frees the slot in the same cycle, so
   // back-to-back reuse of a destination does not lose a cycle.
   assign wr_fire    = bus.i_rf_wen && (bus.i_rf_rdidx != '0);
   assign alloc_rdy  = ~busy_q[bus.i_sb_alloc_idx] |
                       (bus.i_rf_wen && (bus.i_rf_rdidx == bus.i_sb_alloc_idx));
   assign alloc_fire = bus.i_sb_alloc && alloc_rdy && (bus.i_sb_alloc_idx != '0);

   // Counter moves only on a real 0->1 or 1->0 transition. A same-index
   // writeback+alloc on a busy register leaves it busy: no net change.
   assign cnt_inc = alloc_fire & ~busy_q[bus.i_sb_alloc_idx];
   assign cnt_dec = wr_fire & busy_q[bus.i_rf_rdidx] &
                    ~(alloc_fire && (bus.i_sb_alloc_idx == bus.i_rf_rdidx));

   // Register storage
   assign rf_q[0] = '0;

   for (genvar i = 1; i < NREGS; i++) begin : g_reg
      regfile_dfflr #(.W(XLEN)) u_reg (
         .clk (clk),
         .clr (rst),
         .ld  (wr_fire && (bus.i_rf_rdidx == IDXW'(i))),
         .d   (bus.i_rf_wdat),
         .q   (rf_q[i])
      );
   end

   // Busy next-state: clear first, then set, so alloc wins on a collision
   always_comb begin
      busy_nxt = busy_q;
      if (wr_fire)    busy_nxt[bus.i_rf_rdidx]     = 1'b0;
      if (alloc_fire) busy_nxt[bus.i_sb_alloc_idx] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         busy_q <= busy_nxt;
         pend_q <= pend_q + {{IDXW{1'b0}}, cnt_inc} - {{IDXW{1'b0}}, cnt_dec};
      end
   end

   // Read ports
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [IDXW-1:0] rd_idx;
      assign rd_idx = bus.i_rf_rs_idx[k*IDXW +: IDXW];
`ifdef REGFILE_SB_BYPASS_EN
      logic byp_hit;
      assign byp_hit    = wr_fire && (bus.i_rf_rdidx == rd_idx);
      assign rs_data[k] = byp_hit ? bus.i_rf_wdat : rf_q[rd_idx];
      assign rs_busy[k] = busy_q[rd_idx] & ~byp_hit;
`else
      assign rs_data[k] = rf_q[rd_idx];
      assign rs_busy[k] = busy_q[rd_idx];
`endif
   end

   assign bus.o_rf_rs        = rs_data;
   assign bus.o_rf_rs_busy   = rs_busy;
   assign bus.o_sb_alloc_rdy = alloc_rdy;
   assign bus.o_sb_pend_cnt  = pend_q;
endmodule

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
// Directed self-checking bench for regfile_sb (default 32x32, 2 read ports).
// Honours REGFILE_SB_BYPASS_EN for the same-cycle read/write scenario.
// ----------------------------------------------------------------------------
module tb_regfile_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int IDXW  = 5;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int a, input int b);
      logic [IDXW-1:0] ia;
      logic [IDXW-1:0] ib;
      ia = a[IDXW-1:0];
      ib = b[IDXW-1:0];
      bus.i_rf_rs_idx = {ib, ia};
      #1;
   endtask

   task automatic idle();
      bus.i_rf_wen   = 1'b0;
      bus.i_sb_alloc = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd2; bus.i_rf_wdat = 32'h5;
      bus.i_sb_alloc = 1'b1; bus.i_sb_alloc_idx = 5'd2;
      tick();
      tick();
      rst = 1'b0;
      idle();
      for (int i = 0; i < NREGS; i++) begin
         bus.i_sb_alloc_idx = i[IDXW-1:0];
         set_rd(i, NREGS - 1 - i);
         checks++;
         if (bus.o_rf_rs !== '0) begin
            errors++;
            $display("FAIL reset_data idx=%0d got=%h exp=0", i, bus.o_rf_rs);
         end
         checks++;
         if (bus.o_rf_rs_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy idx=%0d got=%b exp=00", i, bus.o_rf_rs_busy);
         end
         checks++;
         if (bus.o_sb_alloc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_alloc_rdy idx=%0d got=%b exp=1", i, bus.o_sb_alloc_rdy);
         end
      end
      checks++;
      if (bus.o_sb_pend_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reset_pend got=%0d exp=0", bus.o_sb_pend_cnt);
      end
   endtask

   task automatic test_write();
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd5; bus.i_rf_wdat = 32'hDEADBEEF;
      tick();
      idle();
      set_rd(5, 5);
      checks++;
      if (bus.o_rf_rs[31:0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write5_port0 got=%h exp=deadbeef", bus.o_rf_rs[31:0]);
      end
      checks++;
      if (bus.o_rf_rs[63:32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write5_port1 got=%h exp=deadbeef", bus.o_rf_rs[63:32]);
      end
      checks++;
      if (bus.o_sb_pend_cnt !== 6'd0) begin
         errors++;
         $display("FAIL write_nonbusy_pend got=%0d exp=0", bus.o_sb_pend_cnt);
      end
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd0; bus.i_rf_wdat = 32'h1234;
      tick();
      idle();
      set_rd(0, 5);
      checks++;
      if (bus.o_rf_rs[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL write0_ignored got=%h exp=0", bus.o_rf_rs[31:0]);
      end
      checks++;
      if (bus.o_sb_pend_cnt !== 6'd0) begin
         errors++;
         $display("FAIL write0_pend got=%0d exp=0", bus.o_sb_pend_cnt);
      end
   endtask

   task automatic test_alloc();
      bus.i_sb_alloc = 1'b1; bus.i_sb_alloc_idx = 5'd7;
      tick();
      idle();
      set_rd(7, 0);
      checks++;
      if (bus.o_rf_rs_busy !== 2'b01) begin
         errors++;
         $display("FAIL alloc7_busy got=%b exp=01", bus.o_rf_rs_busy);
      end
      checks++;
      if (bus.o_sb_pend_cnt !== 6'd1) begin
         errors++;
         $display("FAIL alloc7_pend got=%0d exp=1", bus.o_sb_pend_cnt);
      end
      bus.i_sb_alloc = 1'b1; bus.i_sb_alloc_idx = 5'd7;
      #1;
      checks++;
      if (bus.o_sb_alloc_rdy !== 1'b0) begin
         errors++;
         $display("FAIL realloc7_rdy got=%b exp=0", bus.o_sb_alloc_rdy);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus.o_sb_pend_cnt !== 6'd1 || bus.o_rf_rs_busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL realloc7_nochange pend=%0d busy=%b exp pend=1 busy=1",
                  bus.o_sb_pend_cnt, bus.o_rf_rs_busy[0]);
      end
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd7; bus.i_rf_wdat = 32'h55;
      tick();
      idle();
      #1;
      checks++;
      if (bus.o_rf_rs_busy[0] !== 1'b0 || bus.o_sb_pend_cnt !== 6'd0) begin
         errors++;
         $display("FAIL wb7_clear busy=%b pend=%0d exp busy=0 pend=0",
                  bus.o_rf_rs_busy[0], bus.o_sb_pend_cnt);
      end
      checks++;
      if (bus.o_rf_rs[31:0] !== 32'h55) begin
         errors++;
         $display("FAIL wb7_data got=%h exp=55", bus.o_rf_rs[31:0]);
      end
   endtask

   task automatic test_same_cycle();
      bus.i_sb_alloc = 1'b1; bus.i_sb_alloc_idx = 5'd3;
      tick();
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd3; bus.i_rf_wdat = 32'hA5;
      bus.i_sb_alloc = 1'b1; bus.i_sb_alloc_idx = 5'd3;
      set_rd(3, 3);
      checks++;
      if (bus.o_sb_alloc_rdy !== 1'b1) begin
         errors++;
         $display("FAIL collide3_rdy got=%b exp=1", bus.o_sb_alloc_rdy);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus.o_rf_rs[31:0] !== 32'hA5) begin
         errors++;
         $display("FAIL collide3_data got=%h exp=a5", bus.o_rf_rs[31:0]);
      end
      checks++;
      if (bus.o_rf_rs_busy !== 2'b11 || bus.o_sb_pend_cnt !== 6'd1) begin
         errors++;
         $display("FAIL collide3_busy busy=%b pend=%0d exp busy=11 pend=1",
                  bus.o_rf_rs_busy, bus.o_sb_pend_cnt);
      end
      // Free 3 while allocating 1: one clear plus one set, count unchanged
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd3; bus.i_rf_wdat = 32'hA6;
      bus.i_sb_alloc = 1'b1; bus.i_sb_alloc_idx = 5'd1;
      tick();
      idle();
      set_rd(1, 3);
      checks++;
      if (bus.o_rf_rs_busy !== 2'b01 || bus.o_sb_pend_cnt !== 6'd1) begin
         errors++;
         $display("FAIL swap_busy busy=%b pend=%0d exp busy=01 pend=1",
                  bus.o_rf_rs_busy, bus.o_sb_pend_cnt);
      end
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd1; bus.i_rf_wdat = 32'h1;
      tick();
      idle();
      #1;
      checks++;
      if (bus.o_sb_pend_cnt !== 6'd0) begin
         errors++;
         $display("FAIL swap_drain_pend got=%0d exp=0", bus.o_sb_pend_cnt);
      end
   endtask

   task automatic test_bypass();
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd9; bus.i_rf_wdat = 32'h11;
      tick();
      idle();
      bus.i_sb_alloc = 1'b1; bus.i_sb_alloc_idx = 5'd9;
      tick();
      idle();
      bus.i_rf_wen = 1'b1; bus.i_rf_rdidx = 5'd9; bus.i_rf_wdat = 32'h77;
      set_rd(0, 9);
`ifdef REGFILE_SB_BYPASS_EN
      checks++;
      if (bus.o_rf_rs[63:32] !== 32'h77 || bus.o_rf_rs_busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL bypass_same data=%h busy=%b exp data=77 busy=0",
                  bus.o_rf_rs[63:32], bus.o_rf_rs_busy[1]);
      end
`else
      checks++;
      if (bus.o_rf_rs[63:32] !== 32'h11 || bus.o_rf_rs_busy[1] !== 1'b1) begin
         errors++;
         $display("FAIL nobypass_same data=%h busy=%b exp data=11 busy=1",
                  bus.o_rf_rs[63:32], bus.o_rf_rs_busy[1]);
      end
`endif
      tick();
      idle();
      #1;
      checks++;
      if (bus.o_rf_rs[63:32] !== 32'h77 || bus.o_rf_rs_busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL wb9_next data=%h busy=%b exp data=77 busy=0",
                  bus.o_rf_rs[63:32], bus.o_rf_rs_busy[1]);
      end
   endtask

   task automatic test_reset_mid();
      bus.i_sb_alloc = 1'b1; bus.i_sb_alloc_idx = 5'd4;
      tick();
      bus.i_sb_alloc_idx = 5'd6;
      tick();
      bus.i_sb_alloc_idx = 5'd8;
      tick();
      checks++;
      if (bus.o_sb_pend_cnt !== 6'd3) begin
         errors++;
         $display("FAIL three_alloc_pend got=%0d exp=3", bus.o_sb_pend_cnt);
      end
      rst = 1'b1;
      bus.i_sb_alloc_idx = 5'd10;
      tick();
      rst = 1'b0;
      idle();
      #1;
      checks++;
      if (bus.o_sb_pend_cnt !== 6'd0) begin
         errors++;
         $display("FAIL midrst_pend got=%0d exp=0", bus.o_sb_pend_cnt);
      end
      for (int i = 4; i <= 10; i += 2) begin
         set_rd(i, 5);
         checks++;
         if (bus.o_rf_rs_busy !== 2'b00) begin
            errors++;
            $display("FAIL midrst_busy idx=%0d got=%b exp=00", i, bus.o_rf_rs_busy);
         end
      end
      checks++;
      if (bus.o_rf_rs[63:32] !== 32'h0) begin
         errors++;
         $display("FAIL midrst_data5 got=%h exp=0", bus.o_rf_rs[63:32]);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.i_rf_rs_idx = '0;
      bus.i_rf_wen = 1'b0; bus.i_rf_rdidx = '0; bus.i_rf_wdat = '0;
      bus.i_sb_alloc = 1'b0; bus.i_sb_alloc_idx = '0;
      test_reset();
      test_write();
      test_alloc();
      test_same_cycle();
      test_bypass();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
